// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the memory stage: instruction codes, status codes,
// register sentinel and the small select enums used by the request decoder.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {ASEL_ZERO, ASEL_VALE, ASEL_VALA} addr_sel_e;
    typedef enum logic       {DSEL_VALA, DSEL_VALP}            data_sel_e;
    typedef enum logic       {ST_RUN, ST_HALTED}               run_state_e;

endpackage

// File: rtl/y86_mem_decode.sv
// Combinational icode decoder: which memory access an instruction makes and
// where its address and write data come from.
module y86_mem_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       rd,
    output logic       wr,
    output addr_sel_e  addr_sel,
    output data_sel_e  data_sel
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        rd       = 1'b0;
        wr       = 1'b0;
        addr_sel = ASEL_ZERO;
        data_sel = DSEL_VALA;
        case (icode)
            IRMMOVQ, IPUSHQ: begin
                wr       = 1'b1;
                addr_sel = ASEL_VALE;
            end
            ICALL: begin
                wr       = 1'b1;
                addr_sel = ASEL_VALE;
                data_sel = DSEL_VALP;
            end
            IMRMOVQ: begin
                rd       = 1'b1;
                addr_sel = ASEL_VALE;
            end
            IPOPQ, IRET: begin
                rd       = 1'b1;
                addr_sel = ASEL_VALA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/y86_mem_stage.sv
// Y86-64 memory stage: M/W pipeline registers, data-memory request generation and
// sticky halt. Define MEM_ALIGN_CHECK_EN to fault any access not 8-byte aligned.
module y86_mem_stage
    import y86_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        e_icode,
    input  logic [2:0]        e_stat,
    input  logic [ADDR_W-1:0] e_valE,
    input  logic [DATA_W-1:0] e_valA,
    input  logic [ADDR_W-1:0] e_valP,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        e_dstM,
    input  logic              m_stall,
    input  logic              m_bubble,
    input  logic              w_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] valM,
    input  logic              dmem_error,
    output logic [2:0]        m_stat,
    output logic [3:0]        w_icode,
    output logic [2:0]        w_stat,
    output logic [ADDR_W-1:0] w_valE,
    output logic [DATA_W-1:0] w_valM,
    output logic [3:0]        w_dstE,
    output logic [3:0]        w_dstM,
    output logic              halted
);

    logic [3:0]        m_icode;
    logic [2:0]        m_stat_r;
    logic [ADDR_W-1:0] m_valE;
    logic [DATA_W-1:0] m_valA;
    logic [ADDR_W-1:0] m_valP;
    logic [3:0]        m_dstE;
    logic [3:0]        m_dstM;

    logic       dec_rd;
    logic       dec_wr;
    addr_sel_e  addr_sel;
    data_sel_e  data_sel;
    logic       access_err;
    run_state_e state_q;
    run_state_e state_d;

    // M register: bubble wins over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            m_icode  <= INOP;
            m_stat_r <= SAOK;
            m_valE   <= '0;
            m_valA   <= '0;
            m_valP   <= '0;
            m_dstE   <= RNONE;
            m_dstM   <= RNONE;
        end else if (m_bubble) begin
            m_icode  <= INOP;
            m_stat_r <= SAOK;
            m_valE   <= '0;
            m_valA   <= '0;
            m_valP   <= '0;
            m_dstE   <= RNONE;
            m_dstM   <= RNONE;
        end else if (!m_stall) begin
            m_icode  <= e_icode;
            m_stat_r <= e_stat;
            m_valE   <= e_valE;
            m_valA   <= e_valA;
            m_valP   <= e_valP;
            m_dstE   <= e_dstE;
            m_dstM   <= e_dstM;
        end
    end

    y86_mem_decode u_decode (
        .icode    (m_icode),
        .rd       (dec_rd),
        .wr       (dec_wr),
        .addr_sel (addr_sel),
        .data_sel (data_sel)
    );

    always_comb begin
        mem_addr = '0;
        case (addr_sel)
            ASEL_VALE: mem_addr = m_valE;
            ASEL_VALA: mem_addr = ADDR_W'(m_valA);
            default:   mem_addr = '0;
        endcase
        mem_data = (data_sel == DSEL_VALP) ? DATA_W'(m_valP) : m_valA;
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign access_err = dmem_error | (mem_addr[2:0] != 3'b000);
`else
    assign access_err = dmem_error;
`endif

    // Fault detection uses the raw decode so m_stat never depends on the gated strobes.
    assign m_stat    = ((dec_rd | dec_wr) && access_err) ? SADR : m_stat_r;
    assign mem_write = dec_wr && (m_stat == SAOK) && (w_stat == SAOK) && (state_q == ST_RUN);
    assign mem_read  = dec_rd && (state_q == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_icode <= INOP;
            w_stat  <= SAOK;
            w_valE  <= '0;
            w_valM  <= '0;
            w_dstE  <= RNONE;
            w_dstM  <= RNONE;
        end else if (!w_stall) begin
            w_icode <= m_icode;
            w_stat  <= m_stat;
            w_valE  <= m_valE;
            w_valM  <= mem_read ? valM : '0;
            w_dstE  <= m_dstE;
            w_dstM  <= m_dstM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // HALTED is sticky; only reset leaves it.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && !w_stall && m_stat != SAOK)
            state_d = ST_HALTED;
    end

    assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_y86_mem_stage.sv
// Self-checking bench for y86_mem_stage: table-driven request vectors with a W-stage
// scoreboard, plus hand sequences for halt, bubble/stall, reset and alignment.
module tb_y86_mem_stage;
    import y86_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  e_icode;
    logic [2:0]  e_stat;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [63:0] e_valP;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        m_stall;
    logic        m_bubble;
    logic        w_stall;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic [63:0] valM;
    logic        dmem_error;
    logic [2:0]  m_stat;
    logic [3:0]  w_icode;
    logic [2:0]  w_stat;
    logic [63:0] w_valE;
    logic [63:0] w_valM;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic        halted;

    y86_mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .e_icode    (e_icode),
        .e_stat     (e_stat),
        .e_valE     (e_valE),
        .e_valA     (e_valA),
        .e_valP     (e_valP),
        .e_dstE     (e_dstE),
        .e_dstM     (e_dstM),
        .m_stall    (m_stall),
        .m_bubble   (m_bubble),
        .w_stall    (w_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .valM       (valM),
        .dmem_error (dmem_error),
        .m_stat     (m_stat),
        .w_icode    (w_icode),
        .w_stat     (w_stat),
        .w_valE     (w_valE),
        .w_valM     (w_valM),
        .w_dstE     (w_dstE),
        .w_dstM     (w_dstM),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valP;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [63:0] valM;
        logic        err;
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  mstat;
    } vec_t;

    typedef struct {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } w_exp_t;

    int     n_pass  = 0;
    int     n_total = 0;
    vec_t   vecs[8];
    w_exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive_e(input logic [3:0] icode, input logic [63:0] ve, input logic [63:0] va,
                           input logic [63:0] vp, input logic [3:0] de, input logic [3:0] dm);
        e_icode = icode;
        e_stat  = SAOK;
        e_valE  = ve;
        e_valA  = va;
        e_valP  = vp;
        e_dstE  = de;
        e_dstM  = dm;
    endtask

    task automatic check_w_front(input string tag);
        w_exp_t x;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        n_pass++;
        x = sb.pop_front();
        check({tag, " w_icode"}, 64'(w_icode), 64'(x.icode));
        check({tag, " w_stat"},  64'(w_stat),  64'(x.stat));
        check({tag, " w_valE"},  w_valE, x.valE);
        check({tag, " w_valM"},  w_valM, x.valM);
        check({tag, " w_dstE"},  64'(w_dstE),  64'(x.dstE));
        check({tag, " w_dstM"},  64'(w_dstM),  64'(x.dstM));
    endtask

    initial begin
        //           icode    valE       valA                   valP   dstE   dstM   valM       err   rd    wr    addr       data                   mstat
        vecs[0] = '{IRMMOVQ, 64'h10,    64'h1122334455667788, 64'h0, RNONE, RNONE, 64'hDEAD, 1'b0, 1'b0, 1'b1, 64'h10,    64'h1122334455667788, SAOK};
        vecs[1] = '{IMRMOVQ, 64'h10,    64'h0,                64'h0, RNONE, 4'h3,  64'hAB,   1'b0, 1'b1, 1'b0, 64'h10,    64'h0,                SAOK};
        vecs[2] = '{ICALL,   64'h78,    64'h5,                64'h40, 4'h4, RNONE, 64'h0,    1'b0, 1'b0, 1'b1, 64'h78,    64'h40,               SAOK};
        vecs[3] = '{IPOPQ,   64'h88,    64'h80,               64'h0, 4'h4,  4'h6,  64'h1234, 1'b0, 1'b1, 1'b0, 64'h80,    64'h80,               SAOK};
        vecs[4] = '{IRET,    64'h108,   64'h100,              64'h0, 4'h4,  RNONE, 64'h55,   1'b0, 1'b1, 1'b0, 64'h100,   64'h100,              SAOK};
        vecs[5] = '{IPUSHQ,  64'h70,    64'h99,               64'h0, 4'h4,  RNONE, 64'h0,    1'b0, 1'b0, 1'b1, 64'h70,    64'h99,               SAOK};
        vecs[6] = '{INOP,    64'h33,    64'h7,                64'h0, RNONE, RNONE, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,     64'h7,                SAOK};
        vecs[7] = '{4'h6,    64'h7,     64'h3,                64'h0, 4'h2,  RNONE, 64'hEE,   1'b1, 1'b0, 1'b0, 64'h0,     64'h3,                SAOK};

        rst_n = 1'b0; m_stall = 1'b0; m_bubble = 1'b0; w_stall = 1'b0;
        valM = '0; dmem_error = 1'b0;
        drive_e(INOP, 64'h0, 64'h0, 64'h0, RNONE, RNONE);

        // Reset state
        #12;
        check("rst mem_read",  64'(mem_read),  64'd0);
        check("rst mem_write", 64'(mem_write), 64'd0);
        check("rst m_stat",    64'(m_stat),    64'(SAOK));
        check("rst w_icode",   64'(w_icode),   64'(INOP));
        check("rst w_stat",    64'(w_stat),    64'(SAOK));
        check("rst w_dstE",    64'(w_dstE),    64'(RNONE));
        check("rst w_dstM",    64'(w_dstM),    64'(RNONE));
        check("rst halted",    64'(halted),    64'd0);
        rst_n = 1'b1;

        // Table: each vector sits in M for one cycle, its W result shows after the next edge
        for (int i = 0; i < 8; i++) begin
            w_exp_t x;
            drive_e(vecs[i].icode, vecs[i].valE, vecs[i].valA, vecs[i].valP, vecs[i].dstE, vecs[i].dstM);
            @(posedge clk); #1;
            if (i > 0) check_w_front($sformatf("vec%0d", i - 1));
            valM = vecs[i].valM;
            dmem_error = vecs[i].err;
            #1;
            check($sformatf("vec%0d mem_read", i),  64'(mem_read),  64'(vecs[i].rd));
            check($sformatf("vec%0d mem_write", i), 64'(mem_write), 64'(vecs[i].wr));
            check($sformatf("vec%0d mem_addr", i),  mem_addr, vecs[i].addr);
            check($sformatf("vec%0d mem_data", i),  mem_data, vecs[i].data);
            check($sformatf("vec%0d m_stat", i),    64'(m_stat),    64'(vecs[i].mstat));
            x.icode = vecs[i].icode;
            x.stat  = vecs[i].mstat;
            x.valE  = vecs[i].valE;
            x.valM  = vecs[i].rd ? vecs[i].valM : 64'h0;
            x.dstE  = vecs[i].dstE;
            x.dstM  = vecs[i].dstM;
            sb.push_back(x);
        end
        drive_e(INOP, 64'h0, 64'h0, 64'h0, RNONE, RNONE);
        @(posedge clk); #1;
        check_w_front("vec7");
        dmem_error = 1'b0;
        check("table halted", 64'(halted), 64'd0);

        // Faulting store: suppressed, then sticky halt blocks later writes and reads
        drive_e(IRMMOVQ, 64'h20, 64'h77, 64'h0, RNONE, RNONE);
        @(posedge clk); #1;
        dmem_error = 1'b1; #1;
        check("err mem_write", 64'(mem_write), 64'd0);
        check("err m_stat",    64'(m_stat),    64'(SADR));
        check("err halted pre", 64'(halted),   64'd0);
        drive_e(IPUSHQ, 64'h60, 64'h5, 64'h0, 4'h4, RNONE);
        @(posedge clk); #1;
        dmem_error = 1'b0; #1;
        check("err w_stat",      64'(w_stat),    64'(SADR));
        check("err w_icode",     64'(w_icode),   64'(IRMMOVQ));
        check("err halted",      64'(halted),    64'd1);
        check("push mem_write",  64'(mem_write), 64'd0);
        check("push mem_addr",   mem_addr,       64'h60);
        drive_e(IMRMOVQ, 64'h48, 64'h0, 64'h0, RNONE, 4'h2);
        @(posedge clk); #1;
        valM = 64'h77; #1;
        check("halt w_stat",     64'(w_stat),   64'(SAOK));
        check("halt mem_read",   64'(mem_read), 64'd0);
        check("halt sticky",     64'(halted),   64'd1);
        @(posedge clk); #1;
        check("halt w_valM",     w_valM, 64'h0);

        // Reset leaves HALTED
        rst_n = 1'b0; #1;
        check("rst2 halted",  64'(halted),  64'd0);
        check("rst2 w_icode", 64'(w_icode), 64'(INOP));
        check("rst2 mem_read", 64'(mem_read), 64'd0);
        #1 rst_n = 1'b1;

        // Bubble beats stall; W stall holds previous contents
        drive_e(IRMMOVQ, 64'h18, 64'hAA, 64'h0, RNONE, RNONE);
        @(posedge clk); #1;
        check("bs store mem_write", 64'(mem_write), 64'd1);
        drive_e(IMRMOVQ, 64'h28, 64'h0, 64'h0, RNONE, 4'h3);
        @(posedge clk); #1;
        valM = 64'hCD;
        check("bs w_icode", 64'(w_icode), 64'(IRMMOVQ));
        drive_e(IPUSHQ, 64'h50, 64'h9, 64'h0, 4'h4, RNONE);
        m_bubble = 1'b1; m_stall = 1'b1; w_stall = 1'b1;
        @(posedge clk); #1;
        m_bubble = 1'b0; w_stall = 1'b0; #1;
        check("bs mem_read",  64'(mem_read),  64'd0);
        check("bs mem_write", 64'(mem_write), 64'd0);
        check("bs m_stat",    64'(m_stat),    64'(SAOK));
        check("bs mem_addr",  mem_addr,       64'h0);
        check("bs hold w_icode", 64'(w_icode), 64'(IRMMOVQ));
        check("bs hold w_valE",  w_valE,       64'h18);
        check("bs hold w_valM",  w_valM,       64'h0);
        @(posedge clk); #1;
        m_stall = 1'b0;
        check("stall M bubble kept", 64'(mem_write), 64'd0);
        check("stall w_icode",       64'(w_icode),   64'(INOP));

        // Asynchronous reset mid-write
        drive_e(IRMMOVQ, 64'h30, 64'h42, 64'h0, RNONE, RNONE);
        @(posedge clk); #1;
        check("mid mem_write before", 64'(mem_write), 64'd1);
        #2 rst_n = 1'b0; #1;
        check("mid mem_write", 64'(mem_write), 64'd0);
        check("mid mem_addr",  mem_addr,       64'h0);
        check("mid halted",    64'(halted),    64'd0);
        check("mid w_icode",   64'(w_icode),   64'(INOP));
        #1 rst_n = 1'b1;

        // Unaligned load
        drive_e(IMRMOVQ, 64'h13, 64'h0, 64'h0, RNONE, 4'h1);
        @(posedge clk); #1;
        dmem_error = 1'b0; #1;
        check("unaligned mem_addr", mem_addr, 64'h13);
        check("unaligned mem_read", 64'(mem_read), 64'd1);
`ifdef MEM_ALIGN_CHECK_EN
        check("unaligned m_stat", 64'(m_stat), 64'(SADR));
`else
        check("unaligned m_stat", 64'(m_stat), 64'(SAOK));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
